// File: rtl/psum_gbf_dbuf_if.sv
// Bundles the accumulator write port and the drain stream of the psum buffer.
// The master side is the surrounding logic; the slave side is the buffer itself.
interface psum_gbf_dbuf_if #(
  parameter int GBF_DATA_BITWIDTH = 512,
  parameter int ADDR_BITWIDTH     = 5
);
  logic                         w_en;
  logic [ADDR_BITWIDTH-1:0]     w_addr;
  logic                         w_num;
  logic [GBF_DATA_BITWIDTH-1:0] w_data;
  logic                         acc_en;
  logic                         bank_done;
  logic [1:0]                   bank_full;
  logic                         rd_valid;
  logic                         rd_ready;
  logic [GBF_DATA_BITWIDTH-1:0] rd_data;
  logic [ADDR_BITWIDTH-1:0]     rd_addr;
  logic                         rd_bank;
  logic                         rd_last;
  logic                         err;

  modport master (
    output w_en, w_addr, w_num, w_data, acc_en, bank_done, rd_ready,
    input  bank_full, rd_valid, rd_data, rd_addr, rd_bank, rd_last, err
  );

  modport slave (
    input  w_en, w_addr, w_num, w_data, acc_en, bank_done, rd_ready,
    output bank_full, rd_valid, rd_data, rd_addr, rd_bank, rd_last, err
  );
endinterface

// File: rtl/psum_gbf_dbuf.sv
// Two-bank psum buffer: 2-stage overwrite/accumulate write path, write latency 2 edges.
// Drain FSM streams full banks alternately (0,1,0,...); rd_data/rd_addr hold while rd_ready=0.
module psum_gbf_dbuf #(
  parameter int DATA_BITWIDTH     = 16,
  parameter int GBF_DATA_BITWIDTH = 512,
  parameter int DEPTH             = 32,
  parameter int ADDR_BITWIDTH     = 5
) (
  input  logic          clk,
  input  logic          reset,
  psum_gbf_dbuf_if.slave bus
);
  localparam int LANES = GBF_DATA_BITWIDTH / DATA_BITWIDTH;
  localparam logic [ADDR_BITWIDTH-1:0] LAST_ADDR = ADDR_BITWIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  logic [GBF_DATA_BITWIDTH-1:0] mem [2][DEPTH];

  logic                         s1_en, s1_num, s1_acc, s1_done;
  logic [ADDR_BITWIDTH-1:0]     s1_addr;
  logic [GBF_DATA_BITWIDTH-1:0] s1_data;

  logic [GBF_DATA_BITWIDTH-1:0] wr_old, wr_sum, wr_word;
  logic                         wr_commit;

  state_t                       state, state_n;
  logic [1:0]                   bank_full, full_n;
  logic                         err, err_n;
  logic                         rd_valid, vld_n;
  logic [GBF_DATA_BITWIDTH-1:0] rd_data, data_n;
  logic [ADDR_BITWIDTH-1:0]     rd_addr, addr_n;
  logic                         rd_bank, bank_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_en   <= 1'b0;
      s1_num  <= 1'b0;
      s1_acc  <= 1'b0;
      s1_done <= 1'b0;
      s1_addr <= '0;
      s1_data <= '0;
    end else begin
      s1_en   <= bus.w_en;
      s1_num  <= bus.w_num;
      s1_acc  <= bus.acc_en;
      s1_done <= bus.bank_done;
      s1_addr <= bus.w_addr;
      s1_data <= bus.w_data;
    end
  end

  // Reading the array here (not a registered copy) lets back-to-back writes
  // to one address see the previous commit.
  assign wr_old = mem[s1_num][s1_addr];

  always_comb begin
    wr_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      wr_sum[i*DATA_BITWIDTH +: DATA_BITWIDTH] =
        wr_old[i*DATA_BITWIDTH +: DATA_BITWIDTH] + s1_data[i*DATA_BITWIDTH +: DATA_BITWIDTH];
    end
  end

  assign wr_word   = s1_acc ? wr_sum : s1_data;
  assign wr_commit = s1_en && !bank_full[s1_num];

  always_ff @(posedge clk) begin
    if (wr_commit) begin
      mem[s1_num][s1_addr] <= wr_word;
    end
  end

  always_comb begin
    state_n = state;
    full_n  = bank_full;
    err_n   = err;
    vld_n   = rd_valid;
    data_n  = rd_data;
    addr_n  = rd_addr;
    bank_n  = rd_bank;

    if (s1_en && bank_full[s1_num]) begin
      err_n = 1'b1;
    end
    // A bank being drained is still full, so a done pulse colliding with its
    // clear flags err here and the clear below wins.
    if (s1_done) begin
      if (bank_full[s1_num]) begin
        err_n = 1'b1;
      end else begin
        full_n[s1_num] = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (bank_full[rd_bank]) begin
          state_n = LOAD;
          addr_n  = '0;
        end
      end
      LOAD: begin
        data_n  = mem[rd_bank][rd_addr];
        vld_n   = 1'b1;
        state_n = DRAIN;
      end
      DRAIN: begin
        if (rd_valid && bus.rd_ready) begin
          if (rd_addr == LAST_ADDR) begin
            vld_n           = 1'b0;
            full_n[rd_bank] = 1'b0;
            bank_n          = ~rd_bank;
            state_n         = IDLE;
          end else begin
            addr_n = rd_addr + ADDR_BITWIDTH'(1);
            data_n = mem[rd_bank][addr_n];
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bank_full <= 2'b00;
      err       <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_addr   <= '0;
      rd_bank   <= 1'b0;
    end else begin
      state     <= state_n;
      bank_full <= full_n;
      err       <= err_n;
      rd_valid  <= vld_n;
      rd_data   <= data_n;
      rd_addr   <= addr_n;
      rd_bank   <= bank_n;
    end
  end

  assign bus.bank_full = bank_full;
  assign bus.err       = err;
  assign bus.rd_valid  = rd_valid;
  assign bus.rd_data   = rd_data;
  assign bus.rd_addr   = rd_addr;
  assign bus.rd_bank   = rd_bank;
  assign bus.rd_last   = rd_valid && (rd_addr == LAST_ADDR);
endmodule

// File: tb/tb_psum_gbf_dbuf.sv
// Scoreboard bench: writes push expected drain words; a negedge monitor checks every presented beat.
module tb_psum_gbf_dbuf;
  localparam int DW    = 16;
  localparam int GW    = 512;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  psum_gbf_dbuf_if #(.GBF_DATA_BITWIDTH(GW), .ADDR_BITWIDTH(AW)) bus();

  psum_gbf_dbuf #(
    .DATA_BITWIDTH(DW), .GBF_DATA_BITWIDTH(GW), .DEPTH(DEPTH), .ADDR_BITWIDTH(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct packed {
    logic          bank;
    logic [AW-1:0] addr;
    logic [GW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          q[$];
  logic [GW-1:0] model [2][DEPTH];
  int            compared   = 0;
  int            mismatched = 0;
  int            beats      = 0;
  bit            mon_en     = 1'b0;
  int            rdy_mode   = 0;

  function automatic logic [GW-1:0] lanes(input logic [15:0] v);
    return {32{v}};
  endfunction

  function automatic logic [GW-1:0] lane_add(input logic [GW-1:0] a, input logic [GW-1:0] b);
    logic [GW-1:0] r;
    r = '0;
    for (int i = 0; i < GW / DW; i++) r[i*DW +: DW] = a[i*DW +: DW] + b[i*DW +: DW];
    return r;
  endfunction

  task automatic check(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wr(input bit b, input int a, input logic [15:0] v,
                    input bit acc, input bit done, input bit drop);
    bus.w_en      = 1'b1;
    bus.w_num     = b;
    bus.w_addr    = AW'(a);
    bus.w_data    = lanes(v);
    bus.acc_en    = acc;
    bus.bank_done = done;
    if (!drop) model[b][a] = acc ? lane_add(model[b][a], lanes(v)) : lanes(v);
    if (done) begin
      for (int j = 0; j < DEPTH; j++)
        q.push_back('{bank: b, addr: AW'(j), data: model[b][j], last: (j == DEPTH - 1)});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.w_en      = 1'b0;
    bus.bank_done = 1'b0;
    bus.acc_en    = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic fill(input bit b, input logic [15:0] base);
    for (int i = 0; i < DEPTH; i++) wr(b, i, base + 16'(i), 1'b0, i == DEPTH - 1, 1'b0);
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while ((q.size() != 0 || bus.rd_valid) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    compared++;
    if (n >= limit) begin
      mismatched++;
      $display("FAIL drain_timeout: got %0d words left want 0", q.size());
    end
  endtask

  // 1,0,0,1 pattern in mode 1; mode 2 stalls the drain.
  initial begin
    int k;
    k = 0;
    bus.rd_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: bus.rd_ready = 1'b1;
        1: begin bus.rd_ready = (k % 4 == 0) || (k % 4 == 3); k++; end
        default: bus.rd_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!reset && mon_en && bus.rd_valid) begin
      compared++;
      if (q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_beat: got bank %0d addr %0d want no beat", bus.rd_bank, bus.rd_addr);
      end else begin
        if (bus.rd_data !== q[0].data || bus.rd_addr !== q[0].addr ||
            bus.rd_bank !== q[0].bank || bus.rd_last !== q[0].last) begin
          mismatched++;
          $display("FAIL beat%s: got b%0d a%0d l%0d d=%0h want b%0d a%0d l%0d d=%0h",
                   bus.rd_ready ? "" : "_hold", bus.rd_bank, bus.rd_addr, bus.rd_last, bus.rd_data,
                   q[0].bank, q[0].addr, q[0].last, q[0].data);
        end
        if (bus.rd_ready) begin
          void'(q.pop_front());
          beats++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.w_en = 1'b0; bus.w_num = 1'b0; bus.w_addr = '0; bus.w_data = '0;
    bus.acc_en = 1'b0; bus.bank_done = 1'b0;
    reset = 1'b1;
    #12;
    check("rst_bank_full", GW'(bus.bank_full), '0);
    check("rst_rd_valid",  GW'(bus.rd_valid), '0);
    check("rst_rd_data",   bus.rd_data, '0);
    check("rst_rd_addr",   GW'(bus.rd_addr), '0);
    check("rst_rd_bank",   GW'(bus.rd_bank), '0);
    check("rst_rd_last",   GW'(bus.rd_last), '0);
    check("rst_err",       GW'(bus.err), '0);
    @(posedge clk); #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Overwrite bank 0 with lanes = addr, then drain at full rate.
    beats = 0;
    fill(1'b0, 16'h0000);
    check("full_before_commit", GW'(bus.bank_full), GW'(2'b00));
    idle(1);
    check("full_after_commit", GW'(bus.bank_full), GW'(2'b01));
    wait_drain(200);
    check("t1_beats", GW'(beats), GW'(32));
    check("t1_full_clr", GW'(bus.bank_full), GW'(2'b00));
    check("t1_rd_bank", GW'(bus.rd_bank), GW'(1));

    // Bank 1 with a back-to-back accumulate at addr 5 (0xFFF0+0x0020 wraps to 0x0010), drained under backpressure.
    beats = 0;
    rdy_mode = 1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 5) begin
        wr(1'b1, 5, 16'hFFF0, 1'b0, 1'b0, 1'b0);
        wr(1'b1, 5, 16'h0020, 1'b1, 1'b0, 1'b0);
      end else begin
        wr(1'b1, i, 16'h0100 + 16'(i), 1'b0, i == DEPTH - 1, 1'b0);
      end
    end
    idle(1);
    wait_drain(400);
    rdy_mode = 0;
    check("t2_beats", GW'(beats), GW'(32));
    check("t2_rd_bank", GW'(bus.rd_bank), GW'(0));
    check("t2_full_clr", GW'(bus.bank_full), GW'(2'b00));

    // Ping-pong: bank 1 is written while bank 0 drains.
    beats = 0;
    fill(1'b0, 16'h0200);
    fill(1'b1, 16'h0300);
    idle(1);
    wait_drain(400);
    check("t3_beats", GW'(beats), GW'(64));
    check("t3_err", GW'(bus.err), GW'(0));
    check("t3_rd_bank", GW'(bus.rd_bank), GW'(0));

    // Write into a full bank is dropped and err sticks.
    beats = 0;
    rdy_mode = 2;
    fill(1'b0, 16'h0400);
    idle(2);
    wr(1'b0, 3, 16'hDEAD, 1'b0, 1'b0, 1'b1);
    idle(1);
    check("t4_err_set", GW'(bus.err), GW'(1));
    check("t4_full_held", GW'(bus.bank_full), GW'(2'b01));
    rdy_mode = 0;
    wait_drain(200);
    check("t4_beats", GW'(beats), GW'(32));
    check("t4_err_sticky", GW'(bus.err), GW'(1));
    check("t4_rd_bank", GW'(bus.rd_bank), GW'(1));

    // Async reset at beat 10 of a bank-1 drain.
    beats = 0;
    fill(1'b1, 16'h0500);
    idle(0);
    n = 0;
    while (beats < 10 && n < 200) begin @(negedge clk); #1; n++; end
    check("t5_reach_beat10", GW'(beats), GW'(10));
    reset  = 1'b1;
    mon_en = 1'b0;
    #1;
    check("t5_rd_valid", GW'(bus.rd_valid), GW'(0));
    check("t5_bank_full", GW'(bus.bank_full), GW'(2'b00));
    check("t5_rd_bank", GW'(bus.rd_bank), GW'(0));
    check("t5_err", GW'(bus.err), GW'(0));
    check("t5_rd_addr", GW'(bus.rd_addr), GW'(0));
    q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    idle(4);
    check("t5_post_valid", GW'(bus.rd_valid), GW'(0));
    check("t5_post_full", GW'(bus.bank_full), GW'(2'b00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
